// File: rtl/mem_port_arbiter_if.sv
// Shared-RAM port bundle: datapath fetch/data requests on one side, RAM strobes on the other.
// The arbiter takes the slave view; the environment (datapath plus RAM) takes the master view.
interface mem_port_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;
    logic        proto_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, proto_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, proto_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data access, data first,
// with a starvation bound that forces a fetch after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic          CLK,
    input logic          RST,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StIacc, StDacc} state_e;

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    state_e      state_q;
    logic [3:0]  starve_q;
    logic        ren_q;
    logic        wen_q;
    logic        perr_q;
    logic [31:0] addr_q;
    logic [31:0] store_q;

    logic d_req;
    logic fetch_wins;
    logic ihit_w;
    logic dhit_w;

    assign d_req      = bus.dREN | bus.dWEN;
    assign fetch_wins = bus.iREN & (~d_req | (starve_q >= Limit));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            starve_q <= 4'd0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            perr_q   <= 1'b0;
            addr_q   <= 32'd0;
            store_q  <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (fetch_wins) begin
                        state_q  <= StIacc;
                        starve_q <= 4'd0;
                        ren_q    <= 1'b1;
                        wen_q    <= 1'b0;
                        addr_q   <= bus.iaddr;
                        store_q  <= 32'd0;
                    end else if (d_req) begin
                        state_q  <= StDacc;
                        // Only grants that actually pass over a waiting fetch count.
                        if (!bus.iREN) begin
                            starve_q <= 4'd0;
                        end else if (starve_q < Limit) begin
                            starve_q <= starve_q + 4'd1;
                        end
                        ren_q    <= ~bus.dWEN;
                        wen_q    <= bus.dWEN;
                        addr_q   <= bus.daddr;
                        store_q  <= bus.dstore;
                        if (bus.dREN && bus.dWEN) begin
                            perr_q <= 1'b1;
                        end
                    end
                end
                StIacc, StDacc: begin
                    if (bus.ramready) begin
                        state_q <= StIdle;
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        addr_q  <= 32'd0;
                        store_q <= 32'd0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // A dropped request still lets the RAM finish, but the hit is withheld.
    assign ihit_w = ~RST & (state_q == StIacc) & bus.ramready & bus.iREN;
    assign dhit_w = ~RST & (state_q == StDacc) & bus.ramready & d_req;

    assign bus.ihit      = ihit_w;
    assign bus.dhit      = dhit_w;
    assign bus.iload     = ihit_w ? bus.ramload : 32'd0;
    assign bus.dload     = dhit_w ? bus.ramload : 32'd0;
    assign bus.ramREN    = ren_q;
    assign bus.ramWEN    = wen_q;
    assign bus.ramaddr   = addr_q;
    assign bus.ramstore  = store_q;
    assign bus.proto_err = perr_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized datapath/RAM environment,
// all checked each cycle against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: the transaction currently owning the RAM port, if any.
    bit          m_valid = 0;
    bit          m_fetch = 0;
    bit          m_write = 0;
    logic [31:0] m_addr  = 0;
    logic [31:0] m_data  = 0;
    int          m_streak = 0;
    bit          m_perr  = 0;
    bit          h_i = 0;
    bit          h_d = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit want_i, want_d;
        want_i = bus.iREN;
        want_d = bus.dREN | bus.dWEN;
        if (rst) begin
            m_valid = 0; m_streak = 0; m_perr = 0;
        end else if (m_valid) begin
            if (bus.ramready) m_valid = 0;
        end else if (want_i && (!want_d || m_streak == LIMIT)) begin
            m_valid = 1; m_fetch = 1; m_write = 0;
            m_addr = bus.iaddr; m_data = 0; m_streak = 0;
        end else if (want_d) begin
            m_valid = 1; m_fetch = 0; m_write = bus.dWEN;
            m_addr = bus.daddr; m_data = bus.dstore;
            m_streak = want_i ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
            if (bus.dREN && bus.dWEN) m_perr = 1;
        end
    endtask

    task automatic compare();
        bit ei, ed;
        ei = !rst && m_valid && m_fetch && bus.ramready && bus.iREN;
        ed = !rst && m_valid && !m_fetch && bus.ramready && (bus.dREN || bus.dWEN);
        h_i = ei;
        h_d = ed;
        chk("ihit", bus.ihit, ei);
        chk("dhit", bus.dhit, ed);
        chk("iload", bus.iload, ei ? bus.ramload : 32'd0);
        chk("dload", bus.dload, ed ? bus.ramload : 32'd0);
        chk("ramREN", bus.ramREN, m_valid && !m_write);
        chk("ramWEN", bus.ramWEN, m_valid && m_write);
        chk("ramaddr", bus.ramaddr, m_valid ? m_addr : 32'd0);
        chk("ramstore", bus.ramstore, m_valid ? m_data : 32'd0);
        chk("proto_err", bus.proto_err, m_perr);
    endtask

    task automatic settle();
        @(negedge clk);
        compare();
    endtask

    task automatic clock();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0; bus.ramready = 0;
    endtask

    initial begin
        int seq[$];
        int pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int nd;
        int guard;
        int k;

        bus.iaddr = 0; bus.daddr = 0; bus.dstore = 0; bus.ramload = 0;
        idle_inputs();
        rst = 1;
        clock();
        settle();
        chk("rst_ramREN", bus.ramREN, 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        chk("rst_perr", bus.proto_err, 0);
        clock();
        rst = 0;

        // Lone fetch, RAM ready on the third access cycle.
        bus.iREN = 1; bus.iaddr = 32'h40;
        settle(); clock();
        for (int j = 0; j < 3; j++) begin
            bus.ramready = (j == 2);
            bus.ramload = (j == 2) ? 32'h2401_0005 : 32'h0;
            settle();
            chk("t1_ren", bus.ramREN, 1);
            chk("t1_addr", bus.ramaddr, 32'h40);
            chk("t1_ihit", bus.ihit, (j == 2));
            if (j == 2) chk("t1_iload", bus.iload, 32'h2401_0005);
            clock();
        end
        idle_inputs();
        settle();
        chk("t1_idle_ren", bus.ramREN, 0);
        chk("t1_idle_ihit", bus.ihit, 0);
        clock();

        // Simultaneous fetch and write: data first, fetch next.
        bus.iREN = 1; bus.iaddr = 32'h80;
        bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD_BEEF;
        bus.ramready = 1;
        settle();
        chk("t2_nogrant", bus.ramWEN, 0);
        clock();
        settle();
        chk("t2_wen", bus.ramWEN, 1);
        chk("t2_ren", bus.ramREN, 0);
        chk("t2_addr", bus.ramaddr, 32'h100);
        chk("t2_store", bus.ramstore, 32'hDEAD_BEEF);
        chk("t2_dhit", bus.dhit, 1);
        chk("t2_ihit0", bus.ihit, 0);
        clock();
        bus.dWEN = 0;
        settle();
        chk("t2_gap", bus.ramREN | bus.ramWEN, 0);
        clock();
        settle();
        chk("t2_ihit", bus.ihit, 1);
        chk("t2_iaddr", bus.ramaddr, 32'h80);
        clock();
        bus.iREN = 0;
        settle(); clock();

        // Starvation bound: fetch forced after LIMIT data grants.
        bus.iREN = 1; bus.dREN = 1; bus.daddr = 32'h180; bus.ramready = 1;
        for (int c = 0; c < 22; c++) begin
            bus.ramload = $urandom;
            settle();
            if (bus.dhit) seq.push_back(0);
            if (bus.ihit) seq.push_back(1);
            clock();
        end
        chk("t3_nhits", seq.size() >= 10, 1);
        for (int i = 0; i < 10 && i < seq.size(); i++) chk("t3_order", seq[i], pat[i]);
        bus.iREN = 0; bus.dREN = 0;
        settle(); clock();
        settle(); clock();

        // Cancelled read: RAM still completes, no dhit.
        bus.ramready = 0; bus.dREN = 1; bus.daddr = 32'h200;
        settle(); clock();
        for (int j = 0; j < 4; j++) begin
            if (j == 1) bus.dREN = 0;
            bus.ramready = (j == 3);
            settle();
            chk("t4_ren", bus.ramREN, 1);
            chk("t4_dhit", bus.dhit, 0);
            clock();
        end
        bus.ramready = 0;
        settle();
        chk("t4_idle", bus.ramREN, 0);
        clock();
        bus.dREN = 1; bus.daddr = 32'h204; bus.ramready = 1; bus.ramload = 32'h1357_9BDF;
        settle(); clock();
        settle();
        chk("t4_next_dhit", bus.dhit, 1);
        chk("t4_next_dload", bus.dload, 32'h1357_9BDF);
        clock();
        idle_inputs();
        settle(); clock();

        // Reset mid-write after three starving data grants; counter must restart at 0.
        bus.iREN = 1; bus.iaddr = 32'h88; bus.dREN = 1; bus.daddr = 32'h2F0; bus.ramready = 1;
        nd = 0; guard = 0;
        while (nd < 3 && guard < 20) begin
            settle();
            if (h_d) nd++;
            clock();
            guard++;
        end
        chk("t5_setup", nd, 3);
        bus.dREN = 0; bus.dWEN = 1; bus.daddr = 32'h300; bus.dstore = 32'h1234; bus.ramready = 0;
        settle(); clock();
        settle();
        chk("t5_wen", bus.ramWEN, 1);
        clock();
        rst = 1; bus.ramready = 1;
        settle();
        chk("t5_rst_dhit", bus.dhit, 0);
        clock();
        rst = 0; bus.dWEN = 0; bus.dREN = 1; bus.daddr = 32'h304; bus.ramready = 0;
        settle();
        chk("t5_wen0", bus.ramWEN, 0);
        chk("t5_ren0", bus.ramREN, 0);
        chk("t5_addr0", bus.ramaddr, 0);
        chk("t5_store0", bus.ramstore, 0);
        chk("t5_dhit0", bus.dhit, 0);
        clock();
        bus.ramready = 1;
        settle();
        chk("t5_dfirst", bus.ramaddr, 32'h304);
        chk("t5_dhit", bus.dhit, 1);
        clock();
        idle_inputs();
        settle(); clock();

        // dREN and dWEN together: write, sticky proto_err.
        bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h400; bus.dstore = 32'hCAFE; bus.ramready = 1;
        settle(); clock();
        settle();
        chk("t6_wen", bus.ramWEN, 1);
        chk("t6_ren", bus.ramREN, 0);
        chk("t6_dhit", bus.dhit, 1);
        clock();
        idle_inputs();
        for (int j = 0; j < 3; j++) begin
            settle();
            chk("t6_perr", bus.proto_err, 1);
            clock();
        end

        // Randomized datapath and RAM behaviour.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (h_i || !bus.iREN) begin
                bus.iREN = ($urandom_range(0, 2) == 0);
                bus.iaddr = $urandom & 32'hFFFF_FFFC;
            end else if ($urandom_range(0, 29) == 0) begin
                bus.iREN = 0;
            end
            if (h_d || !(bus.dREN || bus.dWEN)) begin
                if ($urandom_range(0, 2) == 0) begin
                    k = $urandom_range(0, 15);
                    bus.dREN = (k < 8) || (k == 0);
                    bus.dWEN = (k >= 8) || (k == 0);
                    bus.daddr = $urandom;
                    bus.dstore = $urandom;
                end else begin
                    bus.dREN = 0; bus.dWEN = 0;
                end
            end else if ($urandom_range(0, 29) == 0) begin
                bus.dREN = 0; bus.dWEN = 0;
            end
            bus.ramready = $urandom_range(0, 1);
            bus.ramload = $urandom;
            settle();
            clock();
        end

        idle_inputs();
        rst = 1;
        settle(); clock();
        rst = 0;
        settle();
        chk("final_perr", bus.proto_err, 0);
        clock();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared RAM port between the instruction-fetch path and the data-memory path of the pipelined datapath.
- Data requests have priority over instruction fetches; a bounded-starvation counter guarantees fetch progress.
- Each transaction is latched at grant and runs to completion against a variable-latency RAM.
- Returns single-cycle ihit/dhit pulses and load data to the datapath cache interface.

Parameters:
- STARVE_LIMIT, 4: maximum number of consecutive data grants while iREN is pending before one fetch is forced (range 1..15).

Ports:
- CLK in 1: system clock, rising edge.
- RST in 1: reset, synchronous, active-high.
- iREN in 1: instruction fetch request; held until ihit.
- iaddr in 32: fetch address.
- ihit out 1: fetch complete, one-cycle pulse.
- iload out 32: fetched instruction; valid only when ihit=1.
- dREN in 1: data read request; held until dhit.
- dWEN in 1: data write request; held until dhit.
- daddr in 32: data address.
- dstore in 32: write data.
- dhit out 1: data access complete, one-cycle pulse.
- dload out 32: read data; valid only when dhit=1.
- ramREN out 1: RAM read strobe.
- ramWEN out 1: RAM write strobe.
- ramaddr out 32: RAM address.
- ramstore out 32: RAM write data.
- ramload in 32: RAM read data.
- ramready in 1: RAM access complete this cycle.
- proto_err out 1: sticky flag, set when dREN and dWEN are both sampled high at grant.

Behaviour:
- Reset:
  - State IDLE, starvation counter 0, latched address/data/kind 0.
  - All outputs 0: ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, proto_err.
  - RST high mid-access aborts the access at that edge. The RAM strobes drop the next cycle, and no hit is issued for the aborted access.
- States:
  - IDLE: no RAM strobes; arbitration happens here.
  - IACC: fetch in flight.
  - DACC: data access in flight.
- Arbitration in IDLE (registered grant, one cycle after the request is seen):
  - Only iREN high -> IACC.
  - dREN or dWEN high and iREN low -> DACC.
  - Both paths requesting:
    - Counter < STARVE_LIMIT -> DACC and counter increments.
    - Counter = STARVE_LIMIT -> IACC.
  - Counter clears on every IACC grant and on any DACC grant made while iREN is low. It saturates at STARVE_LIMIT.
  - No request -> stay IDLE.
- Grant latch:
  - On entering an ACC state, the block latches the address, store data and access kind.
  - dREN and dWEN both high -> treated as a write and proto_err is set.
- RAM drive:
  - While in IACC or DACC, ramaddr/ramstore/ramREN/ramWEN are driven from the latched values, stable for the whole access.
  - ramREN=1 for fetches and data reads; ramWEN=1 for writes; never both.
- Completion:
  - ramready=1 in an ACC state completes the access.
  - The matching hit is asserted combinationally in that same cycle, and iload/dload are passed through from ramload.
  - The next state is IDLE. There is always one IDLE cycle between accesses; minimum access latency is 2 cycles from request to hit.
- Cancelled requester: if the requester's REN/WEN is low at completion, the hit is suppressed, but the RAM access still completes. Writes are never abandoned mid-access.
- ramready while in IDLE is ignored.
- ihit and dhit are never high in the same cycle.
- A hit pulse never lasts more than 1 cycle, even if the request is held high afterwards. A new request re-arbitrates in IDLE.
- proto_err clears only on RST.

Test Plan:
1. Lone fetch:
   - Stimulus: iREN=1, iaddr=0x0000_0040; RAM returns ramload=0x2401_0005 with ramready high on the 3rd cycle of IACC.
   - Required: ramREN=1 and ramaddr=0x40 for 3 cycles; ihit=1 and iload=0x2401_0005 for exactly 1 cycle; then IDLE.
2. Simultaneous requests:
   - Stimulus: iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEAD_BEEF), ramready=1 every access cycle.
   - Required: data is granted first; ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF; dhit pulses; the fetch is granted on the following arbitration.
3. Starvation bound:
   - Stimulus: STARVE_LIMIT=4; iREN held high while dREN is re-asserted after every dhit.
   - Required: grants follow the order D,D,D,D,I,D,…; ihit occurs after exactly 4 dhits.
4. Cancelled read:
   - Stimulus: dREN drops during DACC; RAM completes 2 cycles later.
   - Required: RAM read finishes, dhit stays 0, state returns to IDLE, and the next request is serviced normally.
5. Reset mid-access:
   - Stimulus: RST=1 for one cycle while in DACC with ramWEN=1.
   - Required: the next cycle has ramWEN=0 and all outputs 0, no dhit, and counter 0.
6. Protocol error:
   - Stimulus: dREN=1 and dWEN=1 together.
   - Required: write performed, proto_err=1 and stays 1 until RST.
